// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: collects requests into a pending set and hands
// out one granted index at a time over a valid/ready output.
module prio_enc_seq #(
   parameter int LOW_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [2:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       ovf,
   output logic [3:0] pend_cnt
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0] state;
   logic [0:0] state_next;
   logic [7:0] pending;
   logic [7:0] pending_next;
   logic [7:0] cand;
   logic [7:0] sel_mask;
   logic [2:0] sel;
   logic       any;
   logic       load;
   logic       ovf_next;
   logic [3:0] cnt_next;

   assign cand  = pending | req;
   assign any   = |cand;
   assign valid = (state == HOLD);

   // The last match in scan order wins, so scanning downward yields the lowest index.
   always_comb begin
      sel = 3'd0;
      if (LOW_FIRST != 0) begin
         for (int i = 7; i >= 0; i--) begin
            if (cand[i]) sel = 3'(i);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (cand[i]) sel = 3'(i);
         end
      end
   end

   assign sel_mask = 8'b0000_0001 << sel;

   // A grant happens whenever something is available and the output slot is free or being freed.
   assign load = any && ((state == EMPTY) || ready);

   always_comb begin
      state_next = state;
      if (load) begin
         state_next = HOLD;
      end else if ((state == HOLD) && ready) begin
         state_next = EMPTY;
      end
   end

   assign pending_next = load ? (cand & ~sel_mask) : cand;

   // The held code is no longer pending, so re-requesting it is a new request, not a merge.
   assign ovf_next = |(req & pending & ~(load ? sel_mask : 8'h00));

   always_comb begin
      cnt_next = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt_next = cnt_next + {3'd0, pending_next[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         pending  <= 8'h00;
         code     <= 3'd0;
         ovf      <= 1'b0;
         pend_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         pending  <= pending_next;
         ovf      <= ovf_next;
         pend_cnt <= cnt_next;
         if (load) begin
            code <= sel;
         end
      end
   end

endmodule
